// File: rtl/button_press_classifier_if.sv
// Button classifier signal bundle: the debounced level going in and the
// synchronised level plus one-cycle event pulses coming out.
interface button_press_classifier_if;
    logic i_btn;
    logic o_held;
    logic o_press;
    logic o_release;
    logic o_short;
    logic o_long;
    logic o_repeat;
    logic o_double;

    // Outputs are level/pulse only (no valid/ready): every o_* pulse is one cycle
    // wide, fully registered, and must be consumed in the cycle it is high.
    modport master (
        output i_btn,
        input  o_held, o_press, o_release, o_short, o_long, o_repeat, o_double
    );

    modport slave (
        input  i_btn,
        output o_held, o_press, o_release, o_short, o_long, o_repeat, o_double
    );
endinterface

// File: rtl/button_press_classifier.sv
// Resynchronises a debounced push-button and classifies presses into press/release,
// short, long with auto-repeat, and double-click pulses. All outputs registered.
module button_press_classifier #(
    parameter int SYNC_STAGES   = 2,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int DCLICK_GAP    = 25_000_000
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    button_press_classifier_if.slave   bus,
    output logic [2:0]                 o_state_dbg
);

    localparam int MAX_LR = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int MAX_G  = (MAX_LR > DCLICK_GAP) ? MAX_LR : DCLICK_GAP;
    localparam int FLUSH  = SYNC_STAGES + 1;
    localparam int MAX_C  = (MAX_G > FLUSH) ? MAX_G : FLUSH;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(DCLICK_GAP);
    localparam logic [CNT_W-1:0] FLUSH_C  = CNT_W'(FLUSH);

    typedef enum logic [2:0] {
        S_WAIT_RELEASE   = 3'd0,
        S_IDLE           = 3'd1,
        S_PRESSED        = 3'd2,
        S_LONG_HELD      = 3'd3,
        S_WAIT_SECOND    = 3'd4,
        S_SECOND_PRESSED = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic                   held_q;
    logic                   rise_q;
    logic                   fall_q;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   press_q;
    logic                   release_q;
    logic                   short_q;
    logic                   long_q;
    logic                   repeat_q;
    logic                   double_q;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            held_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_btn};
            held_q <= btn_s;
            rise_q <= btn_s & ~held_q;
            fall_q <= ~btn_s & held_q;
        end
    end

    // Thresholds compare against the incremented value so an event lands exactly
    // N cycles after the pulse that restarted the count.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_WAIT_RELEASE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            double_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            double_q  <= 1'b0;
            unique case (state_q)
                // The synchroniser resets to "released", so the level is only
                // trusted once it has been flushed with real samples.
                S_WAIT_RELEASE: begin
                    cnt_q <= cnt_inc;
                    if (cnt_q >= FLUSH_C && !held_q) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (rise_q) begin
                        press_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_PRESSED;
                    end
                end
                S_PRESSED: begin
                    cnt_q <= cnt_inc;
                    if (fall_q) begin
                        release_q <= 1'b1;
                        if (DCLICK_GAP == 0) begin
                            short_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_WAIT_SECOND;
                        end
                    end else if (cnt_inc == LONG_C) begin
                        long_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_LONG_HELD;
                    end
                end
                S_LONG_HELD: begin
                    cnt_q <= cnt_inc;
                    if (fall_q) begin
                        release_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (REPEAT_CYCLES != 0 && cnt_inc == REPEAT_C) begin
                        repeat_q <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                S_WAIT_SECOND: begin
                    cnt_q <= cnt_inc;
                    if (rise_q) begin
                        press_q <= 1'b1;
                        state_q <= S_SECOND_PRESSED;
                    end else if (cnt_inc == GAP_C) begin
                        short_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_SECOND_PRESSED: begin
                    if (fall_q) begin
                        release_q <= 1'b1;
                        double_q  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_WAIT_RELEASE;
            endcase
        end
    end

    assign bus.o_held    = held_q;
    assign bus.o_press   = press_q;
    assign bus.o_release = release_q;
    assign bus.o_short   = short_q;
    assign bus.o_long    = long_q;
    assign bus.o_repeat  = repeat_q;
    assign bus.o_double  = double_q;
    assign o_state_dbg   = state_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: a double-click build and a DCLICK_GAP=0 build
// share one button, each checked every cycle against an event-timestamp model.
module tb_button_press_classifier;

    localparam int LONG = 20;
    localparam int REP  = 5;
    localparam int GAP  = 10;

    localparam int B_HELD  = 6;
    localparam int B_PRESS = 5;
    localparam int B_REL   = 4;
    localparam int B_SHORT = 3;
    localparam int B_LONG  = 2;
    localparam int B_REP   = 1;
    localparam int B_DBL   = 0;

    localparam int PH_IDLE   = 0;
    localparam int PH_FIRST  = 1;
    localparam int PH_LONG   = 2;
    localparam int PH_GAP    = 3;
    localparam int PH_SECOND = 4;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic [2:0] dbg_a;
    logic [2:0] dbg_b;

    button_press_classifier_if bif_a ();
    button_press_classifier_if bif_b ();

    button_press_classifier #(
        .SYNC_STAGES(2), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .DCLICK_GAP(GAP)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bif_a), .o_state_dbg(dbg_a)
    );

    button_press_classifier #(
        .SYNC_STAGES(2), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .DCLICK_GAP(0)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bif_b), .o_state_dbg(dbg_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    // reference model state
    int         btn_log[$];
    bit         ready[2];
    int         phase[2];
    int         t_mark[2];
    logic [6:0] exp_v[2];

    // observed-event bookkeeping for scenario checks
    int tally[2][7];
    int last_t[2][7];
    int first_rep[2];

    int hi_len;
    int lo_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int btn_at(input int i);
        if (i >= 1 && i <= btn_log.size()) return btn_log[i-1];
        return 0;
    endfunction

    // Level seen by the classifier at edge n is the button sampled three edges earlier.
    task automatic model_edge(input int m, input int gap);
        int         n;
        int         lvl;
        int         prv;
        bit         rise;
        bit         fall;
        logic [6:0] e;
        n    = btn_log.size();
        lvl  = btn_at(n - 3);
        prv  = btn_at(n - 4);
        rise = (lvl == 1 && prv == 0);
        fall = (lvl == 0 && prv == 1);
        e    = '0;
        e[B_HELD] = (btn_at(n - 2) != 0);
        if (!ready[m]) begin
            if (n >= 4 && lvl == 0) ready[m] = 1'b1;
        end else begin
            case (phase[m])
                PH_IDLE: if (rise) begin
                    e[B_PRESS] = 1'b1; t_mark[m] = n; phase[m] = PH_FIRST;
                end
                PH_FIRST: if (fall) begin
                    e[B_REL] = 1'b1;
                    if (gap == 0) begin e[B_SHORT] = 1'b1; phase[m] = PH_IDLE; end
                    else begin t_mark[m] = n; phase[m] = PH_GAP; end
                end else if (n - t_mark[m] == LONG) begin
                    e[B_LONG] = 1'b1; t_mark[m] = n; phase[m] = PH_LONG;
                end
                PH_LONG: if (fall) begin
                    e[B_REL] = 1'b1; phase[m] = PH_IDLE;
                end else if (REP != 0 && n - t_mark[m] == REP) begin
                    e[B_REP] = 1'b1; t_mark[m] = n;
                end
                PH_GAP: if (rise) begin
                    e[B_PRESS] = 1'b1; phase[m] = PH_SECOND;
                end else if (n - t_mark[m] == gap) begin
                    e[B_SHORT] = 1'b1; phase[m] = PH_IDLE;
                end
                PH_SECOND: if (fall) begin
                    e[B_REL] = 1'b1; e[B_DBL] = 1'b1; phase[m] = PH_IDLE;
                end
                default: phase[m] = PH_IDLE;
            endcase
        end
        exp_v[m] = e;
    endtask

    task automatic clear_tally();
        for (int m = 0; m < 2; m++) begin
            first_rep[m] = -1;
            for (int b = 0; b < 7; b++) begin
                tally[m][b]  = 0;
                last_t[m][b] = -1;
            end
        end
    endtask

    // driver tasks
    task automatic set_btn(input logic v);
        btn         = v;
        bif_a.i_btn = v;
        bif_b.i_btn = v;
    endtask

    task automatic tick();
        logic [6:0] obs[2];
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            exp_v[0] = '0;
            exp_v[1] = '0;
        end else begin
            btn_log.push_back(int'(btn));
            model_edge(0, GAP);
            model_edge(1, 0);
        end
        obs[0] = {bif_a.o_held, bif_a.o_press, bif_a.o_release, bif_a.o_short,
                  bif_a.o_long, bif_a.o_repeat, bif_a.o_double};
        obs[1] = {bif_b.o_held, bif_b.o_press, bif_b.o_release, bif_b.o_short,
                  bif_b.o_long, bif_b.o_repeat, bif_b.o_double};
        check("cycle_gap10", 32'(obs[0]), 32'(exp_v[0]));
        check("cycle_gap0", 32'(obs[1]), 32'(exp_v[1]));
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 6; b++) begin
                if (obs[m][b]) begin
                    tally[m][b]++;
                    last_t[m][b] = cyc;
                    if (b == B_REP && first_rep[m] < 0) first_rep[m] = cyc;
                end
            end
        end
    endtask

    task automatic hold(input logic v, input int cycles);
        set_btn(v);
        repeat (cycles) tick();
    endtask

    task automatic apply_reset(input logic v);
        set_btn(v);
        rst_n = 1'b0;
        btn_log.delete();
        for (int m = 0; m < 2; m++) begin
            ready[m] = 1'b0;
            phase[m] = PH_IDLE;
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_btn(1'b1);
        clear_tally();
        #2;

        // 1: button held through reset is ignored, then press latency is k+3
        apply_reset(1'b1);
        hold(1'b1, 10);
        hold(1'b0, 8);
        check("s1_no_press", 32'(tally[0][B_PRESS] + tally[0][B_SHORT] + tally[0][B_LONG]), 0);
        clear_tally();
        set_btn(1'b1);
        tick();
        tick();
        tick();
        check("s1_press_k2", 32'(bif_a.o_press), 0);
        tick();
        check("s1_press_k3", 32'(bif_a.o_press), 1);
        check("s1_held_k3", 32'(bif_a.o_held), 1);

        // 2: 5-cycle press -> release, short 10 cycles later
        tick();
        hold(1'b0, 15);
        check("s2_press", 32'(tally[0][B_PRESS]), 1);
        check("s2_release", 32'(tally[0][B_REL]), 1);
        check("s2_short", 32'(tally[0][B_SHORT]), 1);
        check("s2_long_dbl", 32'(tally[0][B_LONG] + tally[0][B_DBL]), 0);
        check("s2_short_delay", 32'(last_t[0][B_SHORT] - last_t[0][B_REL]), 10);
        check("s6_gap0_short_delay", 32'(last_t[1][B_SHORT] - last_t[1][B_REL]), 0);
        check("s6_gap0_short", 32'(tally[1][B_SHORT]), 1);

        // 3: long hold with auto-repeat
        clear_tally();
        hold(1'b1, 32);
        hold(1'b0, 15);
        check("s3_long", 32'(tally[0][B_LONG]), 1);
        check("s3_long_t", 32'(last_t[0][B_LONG] - last_t[0][B_PRESS]), 20);
        check("s3_repeat", 32'(tally[0][B_REP]), 2);
        check("s3_rep1_t", 32'(first_rep[0] - last_t[0][B_PRESS]), 25);
        check("s3_rep2_t", 32'(last_t[0][B_REP] - last_t[0][B_PRESS]), 30);
        check("s3_release", 32'(tally[0][B_REL]), 1);
        check("s3_no_short", 32'(tally[0][B_SHORT] + tally[0][B_DBL]), 0);
        check("s3_gap0_no_short", 32'(tally[1][B_SHORT]), 0);

        // 4: double click
        clear_tally();
        hold(1'b1, 5);
        hold(1'b0, 4);
        hold(1'b1, 3);
        hold(1'b0, 15);
        check("s4_press", 32'(tally[0][B_PRESS]), 2);
        check("s4_release", 32'(tally[0][B_REL]), 2);
        check("s4_double", 32'(tally[0][B_DBL]), 1);
        check("s4_double_t", 32'(last_t[0][B_DBL] - last_t[0][B_REL]), 0);
        check("s4_no_short", 32'(tally[0][B_SHORT]), 0);
        check("s4_gap0_shorts", 32'(tally[1][B_SHORT]), 2);
        check("s4_gap0_no_dbl", 32'(tally[1][B_DBL]), 0);

        // 5: boundaries
        clear_tally();
        hold(1'b1, 20);
        hold(1'b0, 15);
        check("s5_fall_at_long_nolong", 32'(tally[0][B_LONG]), 0);
        check("s5_fall_at_long_short", 32'(tally[0][B_SHORT]), 1);
        clear_tally();
        hold(1'b1, 21);
        hold(1'b0, 15);
        check("s5_long_plus1", 32'(tally[0][B_LONG]), 1);
        check("s5_long_plus1_noshort", 32'(tally[0][B_SHORT]), 0);
        clear_tally();
        hold(1'b1, 2);
        hold(1'b0, 10);
        hold(1'b1, 2);
        hold(1'b0, 15);
        check("s5_rise_at_gap_dbl", 32'(tally[0][B_DBL]), 1);
        check("s5_rise_at_gap_noshort", 32'(tally[0][B_SHORT]), 0);
        clear_tally();
        hold(1'b1, 2);
        hold(1'b0, 11);
        hold(1'b1, 2);
        hold(1'b0, 15);
        check("s5_gap_plus1_nodbl", 32'(tally[0][B_DBL]), 0);
        check("s5_gap_plus1_shorts", 32'(tally[0][B_SHORT]), 2);

        // 6: reset while waiting for a second press
        hold(1'b1, 3);
        hold(1'b0, 4);
        clear_tally();
        apply_reset(1'b0);
        hold(1'b0, 20);
        check("s6_reset_no_short", 32'(tally[0][B_SHORT]), 0);
        check("s6_reset_no_dbl", 32'(tally[0][B_DBL]), 0);

        // randomized press/release trains with occasional resets
        for (int i = 0; i < 40; i++) begin
            hi_len = $urandom_range(1, 30);
            lo_len = $urandom_range(1, 14);
            hold(1'b1, hi_len);
            hold(1'b0, lo_len);
            if ($urandom_range(0, 9) == 0) apply_reset(1'($urandom_range(0, 1)));
        end
        hold(1'b0, 25);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
